control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clock  in  1  single clock; all flops are rising-edge.
REQ-003 The block SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port run  in  1  start/resume request, sampled in IDLE and HALTED.
REQ-005 The block SHALL have port halt_req  in  1  request to stop at the next instruction boundary.
REQ-006 The block SHALL have port mem_ready  in  1  memory handshake; high means the current fetch or data access completes this cycle.
REQ-007 The block SHALL have port opcode  in  4  registered opcode from the instruction decoder.
REQ-008 The block SHALL have port en_fetch, en_decode, en_regrd, en_alu, en_mem, en_wb  out  1 each  stage enables; en_decode drives the decoder enable.
REQ-009 The block SHALL have port pc_load  out  1  load the branch target into the PC.
REQ-010 The block SHALL have port busy  out  1  high in every state except IDLE and HALTED.
REQ-011 The block SHALL have port state  out  3  current state encoding.
REQ-012 The block SHALL have port retired  out  CNT_W  count of completed instructions.

Function
REQ-013 The state machine SHALL have the states IDLE=0, FETCH=1, DECODE=2, REGRD=3, ALU=4, MEM=5, WB=6, HALTED=7.
REQ-014 The enables SHALL be Moore outputs decoded from the state register: exactly one of en_fetch..en_wb is high in states FETCH..WB, and none is high in IDLE or HALTED.
REQ-015 In IDLE: run=1 -> FETCH; otherwise stay.
REQ-016 In FETCH: stay while mem_ready=0; go to DECODE on mem_ready=1.
REQ-017 DECODE -> REGRD and REGRD -> ALU SHALL each take exactly one cycle.
REQ-018 In ALU, by opcode:
- OP_LOAD and OP_STORE -> MEM.
- OP_JUMP -> pc_load=1 for that cycle, then instruction end.
- OP_HALT -> HALTED.
- any other opcode -> WB.
REQ-019 In MEM: stay while mem_ready=0; on mem_ready=1, OP_LOAD -> WB and OP_STORE -> instruction end.
REQ-020 WB SHALL take one cycle, then instruction end.
REQ-021 At instruction end: pending halt -> IDLE; otherwise -> FETCH.
REQ-022 In HALTED: run=1 -> FETCH; halt_req has no effect in HALTED.
REQ-023 Pending halt handling:
- halt_req=1 in any busy state SHALL set a sticky pending-halt flag.
- The flag SHALL clear on entry to IDLE or HALTED.
- halt_req in IDLE SHALL be ignored, and run wins.
REQ-024 retired SHALL increment by 1 on the cycle of each instruction end and on ALU->HALTED, and SHALL wrap from all-ones to 0.
REQ-025 With mem_ready held at 1, an ALU instruction SHALL take 5 cycles, LOAD 6, STORE 5, JUMP 4 and HALT 4.
REQ-026 pc_load SHALL be high only in ALU with OP_JUMP.
REQ-027 opcode SHALL be sampled only in ALU and MEM; changes to opcode in other states SHALL have no effect.

Reset
REQ-028 While reset_n=0, the block SHALL hold state=IDLE, all enables=0, pc_load=0, busy=0, retired=0 and the pending-halt flag=0.
REQ-029 Asserting reset_n mid-instruction, including during a mem_ready wait, SHALL abort the instruction without incrementing retired.
REQ-030 After reset_n deasserts, the block SHALL stay in IDLE until run=1.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the opcode constants OP_LOAD=4'b1000, OP_STORE=4'b1001, OP_JUMP=4'b1100 and OP_HALT=4'b1111.
REQ-032 The block SHALL be a single module with no sub-modules: one state register, the pending-halt flag and the retired counter.

Verification
REQ-033 The bench SHALL cover a basic ALU sequence: reset, run pulse, mem_ready=1, opcode=4'b0001 -> states 1,2,3,4,6,1; retired=1 after WB.
REQ-034 The bench SHALL cover memory wait states: LOAD with mem_ready low for 3 cycles in FETCH and 2 in MEM -> instruction takes 11 cycles, en_mem high for 3 cycles.
REQ-035 The bench SHALL cover JUMP then HALT: opcode=OP_JUMP -> pc_load=1 for exactly 1 cycle in ALU; then opcode=OP_HALT -> HALTED, busy=0, retired=2; run -> FETCH.
REQ-036 The bench SHALL cover a halt request in DECODE: halt_req pulse in DECODE of an ALU instruction -> completes WB, then IDLE; next run resumes FETCH.
REQ-037 The bench SHALL cover reset mid-operation: reset_n low while in MEM -> immediately IDLE, enables 0, retired unchanged from its pre-instruction value then cleared to 0.
REQ-038 The bench SHALL cover counter wrap: with CNT_W=4, 17 ALU instructions -> retired=1.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the instruction control sequencer.
// Holds the state encoding and the opcodes that steer the ALU/MEM stages.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_REGRD  = 3'd3,
        ST_ALU    = 3'd4,
        ST_MEM    = 3'd5,
        ST_WB     = 3'd6,
        ST_HALTED = 3'd7
    } state_e;

    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_JUMP  = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH..WB per instruction, honours
// halt requests at instruction boundaries and counts retired instructions.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic             mem_ready,
    input  logic [3:0]       opcode,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_regrd,
    output logic             en_alu,
    output logic             en_mem,
    output logic             en_wb,
    output logic             pc_load,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e             state_q, state_d;
    logic               halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               instr_end;
    logic               retire;
    logic               pend_now;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            halt_pend_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_end = 1'b0;
        retire    = 1'b0;
        pc_load   = 1'b0;
        en_fetch  = 1'b0;
        en_decode = 1'b0;
        en_regrd  = 1'b0;
        en_alu    = 1'b0;
        en_mem    = 1'b0;
        en_wb     = 1'b0;
        busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);
        // A halt raised on the final cycle of an instruction still takes effect.
        pend_now  = halt_pend_q | (busy & halt_req);

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                en_fetch = 1'b1;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                en_decode = 1'b1;
                state_d   = ST_REGRD;
            end
            ST_REGRD: begin
                en_regrd = 1'b1;
                state_d  = ST_ALU;
            end
            ST_ALU: begin
                en_alu = 1'b1;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    OP_JUMP: begin
                        pc_load   = 1'b1;
                        instr_end = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = ST_HALTED;
                        retire  = 1'b1;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                en_mem = 1'b1;
                if (mem_ready) begin
                    if (opcode == OP_LOAD) state_d = ST_WB;
                    else                   instr_end = 1'b1;
                end
            end
            ST_WB: begin
                en_wb     = 1'b1;
                instr_end = 1'b1;
            end
            ST_HALTED: begin
                if (run) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        if (instr_end) begin
            retire  = 1'b1;
            state_d = pend_now ? ST_IDLE : ST_FETCH;
        end

        halt_pend_d = ((state_d == ST_IDLE) || (state_d == ST_HALTED)) ? 1'b0 : pend_now;
        retired_d   = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
